// File: rtl/vlu_pkg.sv
// Shared types and default sizes for the vector load unit.
package vlu_pkg;

  localparam int LANES_DEF = 4;
  localparam int W_DEF     = 8;
  localparam int AW_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vlu_state_t;

endpackage

// File: rtl/vlu_if.sv
// Request, memory and vector handshake bundle of the vector load unit.
// The req_stride field exists only when VLU_STRIDE_EN is defined.
interface vlu_if import vlu_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int W     = W_DEF,
  parameter int AW    = AW_DEF
);

  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_addr;
`ifdef VLU_STRIDE_EN
  logic [AW-1:0]        req_stride;
`endif
  logic                 mem_en;
  logic [AW-1:0]        mem_addr;
  logic [W-1:0]         mem_rdata;
  logic                 vec_valid;
  logic                 vec_ready;
  logic [LANES*W-1:0]   vec_data;

  modport slave (
    input  req_valid,
    input  req_addr,
`ifdef VLU_STRIDE_EN
    input  req_stride,
`endif
    output req_ready,
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    output vec_valid,
    input  vec_ready,
    output vec_data
  );

  modport master (
    output req_valid,
    output req_addr,
`ifdef VLU_STRIDE_EN
    output req_stride,
`endif
    input  req_ready,
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    input  vec_valid,
    output vec_ready,
    input  vec_data
  );

endinterface

// File: rtl/vlu_addr_gen.sv
// Lane counter plus base/stride address generation for the vector load unit.
// Stride comes from the request when VLU_STRIDE_EN is defined, otherwise it is fixed at 1.
module vlu_addr_gen #(
  parameter int LANES = 4,
  parameter int AW    = 16,
  parameter int IW    = $clog2(LANES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] req_base,
`ifdef VLU_STRIDE_EN
  input  logic [AW-1:0] req_stride,
`endif
  output logic [IW-1:0] lane_idx,
  output logic          last_lane,
  output logic [AW-1:0] mem_addr
);

  logic [AW-1:0] base_q;
  logic [AW-1:0] stride;
  logic [IW-1:0] idx_q;

`ifdef VLU_STRIDE_EN
  logic [AW-1:0] stride_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stride_q <= '0;
    end else if (load) begin
      stride_q <= req_stride;
    end
  end

  assign stride = stride_q;
`else
  assign stride = AW'(1);
`endif

  // The counter ends at LANES after the final issue, which is what DRAIN uses to find the last lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      base_q <= req_base;
      idx_q  <= '0;
    end else if (step) begin
      idx_q  <= idx_q + IW'(1);
    end
  end

  assign lane_idx  = idx_q;
  assign last_lane = (idx_q == IW'(LANES - 1));
  assign mem_addr  = base_q + AW'(idx_q) * stride;

endmodule

// File: rtl/vec_load_unit.sv
// Vector load unit: gathers LANES memory words into one vector and hands it downstream.
// Define VLU_STRIDE_EN to take the lane stride from the request instead of using 1.
module vec_load_unit import vlu_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int W     = W_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic  clk,
  input  logic  reset,
  vlu_if.slave  bus,
  output logic  busy
);

  localparam int IW = $clog2(LANES + 1);

  vlu_state_t         state;
  vlu_state_t         state_nx;
  logic               accept;
  logic               issued_q;
  logic               last_lane;
  logic [IW-1:0]      lane_idx;
  logic [IW-1:0]      lane_prev;
  logic [LANES*W-1:0] vec_q;

  assign accept    = bus.req_valid && bus.req_ready;
  assign lane_prev = lane_idx - IW'(1);

  vlu_addr_gen #(
    .LANES (LANES),
    .AW    (AW),
    .IW    (IW)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .step       (bus.mem_en),
    .req_base   (bus.req_addr),
`ifdef VLU_STRIDE_EN
    .req_stride (bus.req_stride),
`endif
    .lane_idx   (lane_idx),
    .last_lane  (last_lane),
    .mem_addr   (bus.mem_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.mem_en    = 1'b0;
    bus.vec_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          state_nx = FETCH;
        end
      end
      FETCH: begin
        bus.mem_en = 1'b1;
        if (last_lane) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        state_nx = DONE;
      end
      DONE: begin
        bus.vec_valid = 1'b1;
        if (bus.vec_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Read data trails its strobe by one cycle, by which time the counter has already moved on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= 1'b0;
      vec_q    <= '0;
    end else begin
      issued_q <= bus.mem_en;
      for (int k = 0; k < LANES; k++) begin
        if (issued_q && (lane_prev == IW'(k))) begin
          vec_q[k*W +: W] <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.vec_data = vec_q;

endmodule

// File: tb/tb_vec_load_unit.sv
// Directed bench for vec_load_unit; the memory returns addr[7:0] ^ addr[15:8] one cycle after mem_en.
// Stride cases run only when VLU_STRIDE_EN is defined.
module tb_vec_load_unit;

  logic clk;
  logic reset;
  logic busy;
  int   compared;
  int   mismatched;

  vlu_if #(.LANES(4), .W(8), .AW(16)) bus ();

  vec_load_unit #(
    .LANES (4),
    .W     (8),
    .AW    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_word(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_en ? mem_word(bus.mem_addr) : 8'h00;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge of the first DONE cycle.
  task automatic apply_stimulus(input string tag, input logic [15:0] base, input logic [15:0] exp_addr [4],
                                input logic [31:0] exp_vec, input bit hold, input logic [15:0] held_addr);
    int cyc;
    bus.req_valid = 1'b1;
    bus.req_addr  = base;
    #1;
    check_output({tag, "/req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    if (hold) begin
      bus.req_addr = held_addr;
    end else begin
      bus.req_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      check_output({tag, "/mem_en"}, 32'(bus.mem_en), 32'd1);
      check_output({tag, "/mem_addr"}, 32'(bus.mem_addr), 32'(exp_addr[i]));
      check_output({tag, "/req_ready_busy"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      cyc++;
    end
    check_output({tag, "/drain_mem_en"}, 32'(bus.mem_en), 32'd0);
    check_output({tag, "/drain_vec_valid"}, 32'(bus.vec_valid), 32'd0);
    while (!bus.vec_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_output({tag, "/valid_cycle"}, 32'(cyc), 32'd6);
    check_output({tag, "/vec_data"}, bus.vec_data, exp_vec);
  endtask

  task automatic release_vector(input string tag, input logic [31:0] exp_vec);
    bus.vec_ready = 1'b1;
    @(negedge clk);
    bus.vec_ready = 1'b0;
    check_output({tag, "/rel_req_ready"}, 32'(bus.req_ready), 32'd1);
    check_output({tag, "/rel_vec_valid"}, 32'(bus.vec_valid), 32'd0);
    check_output({tag, "/rel_busy"}, 32'(busy), 32'd0);
    check_output({tag, "/rel_vec_data"}, bus.vec_data, exp_vec);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.vec_ready = 1'b0;
`ifdef VLU_STRIDE_EN
    bus.req_stride = 16'h0001;
`endif

    $display("[TB] reset values");
    @(negedge clk);
    @(negedge clk);
    check_output("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rst/vec_valid", 32'(bus.vec_valid), 32'd0);
    check_output("rst/mem_en", 32'(bus.mem_en), 32'd0);
    check_output("rst/busy", 32'(busy), 32'd0);
    check_output("rst/mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("rst/vec_data", bus.vec_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] contiguous load and backpressure");
    apply_stimulus("contig", 16'h0010, '{16'h0010, 16'h0011, 16'h0012, 16'h0013}, 32'h13121110, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp/vec_valid", 32'(bus.vec_valid), 32'd1);
      check_output("bp/vec_data", bus.vec_data, 32'h13121110);
      check_output("bp/req_ready", 32'(bus.req_ready), 32'd0);
    end
    release_vector("contig", 32'h13121110);

    $display("[TB] address wrap-around");
    apply_stimulus("wrap", 16'hFFFE, '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}, 32'h01000001, 1'b0, 16'h0000);
    release_vector("wrap", 32'h01000001);

`ifdef VLU_STRIDE_EN
    $display("[TB] strided loads");
    bus.req_stride = 16'h0004;
    apply_stimulus("stride4", 16'h0100, '{16'h0100, 16'h0104, 16'h0108, 16'h010C}, 32'h0D090501, 1'b0, 16'h0000);
    release_vector("stride4", 32'h0D090501);
    bus.req_stride = 16'h0000;
    apply_stimulus("stride0", 16'h0100, '{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 32'h01010101, 1'b0, 16'h0000);
    release_vector("stride0", 32'h01010101);
    bus.req_stride = 16'h0001;
`endif

    $display("[TB] reset during fetch");
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("abort/req_ready", 32'(bus.req_ready), 32'd1);
    check_output("abort/mem_en", 32'(bus.mem_en), 32'd0);
    check_output("abort/busy", 32'(busy), 32'd0);
    check_output("abort/vec_valid", 32'(bus.vec_valid), 32'd0);
    check_output("abort/mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("abort/vec_data", bus.vec_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("abort/no_valid", 32'(bus.vec_valid), 32'd0);
    end
    apply_stimulus("fresh", 16'h0030, '{16'h0030, 16'h0031, 16'h0032, 16'h0033}, 32'h33323130, 1'b0, 16'h0000);
    release_vector("fresh", 32'h33323130);

    $display("[TB] request held while busy");
    apply_stimulus("held1", 16'h0040, '{16'h0040, 16'h0041, 16'h0042, 16'h0043}, 32'h43424140, 1'b1, 16'h0050);
    release_vector("held1", 32'h43424140);
    apply_stimulus("held2", 16'h0050, '{16'h0050, 16'h0051, 16'h0052, 16'h0053}, 32'h53525150, 1'b0, 16'h0000);
    release_vector("held2", 32'h53525150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vec_load_unit.md
VEC_LOAD_UNIT -- requirements
Module: vec_load_unit

Interface
REQ-001 Parameters SHALL be: LANES, default 4, number of vector lanes; W, default 8, lane width in bits; AW, default 16, memory address width.
REQ-002 Port clk SHALL be: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: input, 1 bit; reset is asynchronous and active-high.
REQ-004 Port req_valid SHALL be: input, 1 bit; a vector load request is present.
REQ-005 Port req_ready SHALL be: output, 1 bit; the unit accepts a request this cycle.
REQ-006 Port req_addr SHALL be: input, AW bits; base address of lane 0.
REQ-007 Port req_stride SHALL be: input, AW bits; lane address increment. Present only when VLU_STRIDE_EN is defined.
REQ-008 Port mem_en SHALL be: output, 1 bit; memory read strobe.
REQ-009 Port mem_addr SHALL be: output, AW bits; memory read address.
REQ-010 Port mem_rdata SHALL be: input, W bits; read data, valid exactly 1 cycle after the cycle in which mem_en is asserted.
REQ-011 Port vec_valid SHALL be: output, 1 bit; the assembled vector is available.
REQ-012 Port vec_ready SHALL be: input, 1 bit; the downstream pipeline register accepts the vector.
REQ-013 Port vec_data SHALL be: output, LANES*W bits; lane k occupies bits [k*W +: W].
REQ-014 Port busy SHALL be: output, 1 bit; high in every state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, FETCH, DRAIN and DONE.
REQ-016 In IDLE, req_ready SHALL be 1; on req_valid&&req_ready the unit latches base and stride, clears the lane counter and enters FETCH.
REQ-017 In FETCH, mem_en SHALL be 1 with mem_addr = base + idx*stride (mod 2^AW), where idx runs 0..LANES-1, one lane per cycle.
REQ-018 After issuing idx = LANES-1, the FSM SHALL enter DRAIN for exactly 1 cycle with mem_en = 0.
REQ-019 In each cycle following an issue, mem_rdata SHALL be written into lane idx-1 of the vector buffer; DRAIN captures the last lane.
REQ-020 After DRAIN the FSM SHALL enter DONE, in which vec_valid = 1; vec_valid first rises LANES+2 cycles after the acceptance edge.
REQ-021 In DONE, vec_valid&&vec_ready SHALL return the FSM to IDLE on that edge; otherwise the FSM stays in DONE with vec_data held stable.
REQ-022 req_ready SHALL be 0 in FETCH, DRAIN and DONE; a req_valid arriving then is ignored and is not queued.
REQ-023 Address overflow SHALL wrap modulo 2^AW with no error indication.
REQ-024 vec_data SHALL keep its last value after the handshake until the next capture overwrites it.
REQ-025 mem_en SHALL be 0 outside FETCH.

Reset
REQ-026 While reset is high, the unit SHALL be in IDLE with req_ready = 1 and vec_valid, mem_en, busy = 0, and mem_addr, vec_data, lane counter, base and stride = 0.
REQ-027 Asserting reset mid-operation SHALL abort the load immediately; the partial vector is discarded and no vec_valid is produced.

Configuration
REQ-028 With VLU_STRIDE_EN defined, the stride SHALL be taken from req_stride, and a stride of 0 is legal (all lanes read the same address).
REQ-029 Without VLU_STRIDE_EN, the req_stride port SHALL be absent and the stride is fixed at 1 (contiguous load).

Structure
REQ-030 Package vlu_pkg SHALL hold the FSM state enum typedef and the default constants for LANES, W and AW.
REQ-031 Sub-module vlu_addr_gen SHALL hold base/stride/index address generation and the lane counter; the top level holds the FSM and the vector buffer.

Verification
REQ-032 Contiguous load: LANES = 4, base 0x0010, memory[i] = i -> mem_addr sequence 0x10..0x13, vec_data = 0x13121110, vec_valid rising 6 cycles after acceptance.
REQ-033 Backpressure: vec_ready held 0 for 5 cycles in DONE -> vec_valid stays 1, vec_data unchanged, req_ready stays 0; release -> IDLE on the next edge.
REQ-034 Wrap-around: base 0xFFFE, stride 1 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 Stride (VLU_STRIDE_EN): base 0x0100, stride 0x0004 -> addresses 0x100, 0x104, 0x108, 0x10C; with stride 0, all four lanes equal memory[0x100].
REQ-036 Reset mid-FETCH after 2 lanes -> outputs take their reset values immediately; the next request produces a fully fresh vector.
REQ-037 Request during busy: req_valid held from FETCH onward -> ignored until IDLE, then accepted; back-to-back loads produce 2 correct vectors.
